// File: rtl/csa_pkg.sv
// Shared constants and result type for the carry-save resolver.
// Default geometry: 10-bit sum/carry vectors, low 5 bits resolved in stage 1.
package csa_pkg;

    localparam int W     = 10;
    localparam int SPLIT = 5;

    typedef logic [W:0] result_t;

    localparam result_t SAT_MAX = result_t'((1 << (W - 1)) - 1);
    localparam result_t SAT_MIN = result_t'(-(1 << (W - 1)));

endpackage

// File: rtl/csa_res_slice.sv
// N-bit ripple adder slice with carry-in and carry-out.
module csa_res_slice #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    logic [N:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    assign sum   = total[N-1:0];
    assign co    = total[N];

endmodule

// File: rtl/csa_resolve.sv
// Two-stage carry-save to binary resolver with a stall-able valid/ready pipeline.
// Optional output saturation and saturation counter under `CSA_RESOLVE_SAT_EN.
module csa_resolve #(
    parameter int W     = csa_pkg::W,
    parameter int SPLIT = csa_pkg::SPLIT
) (
    input  logic         clk,
    input  logic         r,
    input  logic [W-1:0] s,
    input  logic [W-1:0] c,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   out_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf,
    output logic [7:0]   sat_cnt
);

    localparam int HI = W - SPLIT;

    logic             en;
    logic [SPLIT-1:0] lo_sum;
    logic             lo_co;

    logic             v1;
    logic [SPLIT-1:0] lo1;
    logic             co1;
    logic [HI-1:0]    sh1;
    logic [HI-1:0]    ch1;

    logic [HI-1:0]    hi_sum;
    logic             hi_co;
    logic [W:0]       y_full;
    logic [W:0]       y_next;
    logic             clamp;

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    csa_res_slice #(.N(SPLIT)) u_lo (
        .a   (s[SPLIT-1:0]),
        .b   (c[SPLIT-1:0]),
        .ci  (1'b0),
        .sum (lo_sum),
        .co  (lo_co)
    );

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            v1  <= 1'b0;
            lo1 <= '0;
            co1 <= 1'b0;
            sh1 <= '0;
            ch1 <= '0;
        end else if (en) begin
            v1  <= in_valid;
            lo1 <= lo_sum;
            co1 <= lo_co;
            sh1 <= s[W-1:SPLIT];
            ch1 <= c[W-1:SPLIT];
        end
    end

    // The registered low carry travels with its own item into the upper add.
    csa_res_slice #(.N(HI)) u_hi (
        .a   (sh1),
        .b   (ch1),
        .ci  (co1),
        .sum (hi_sum),
        .co  (hi_co)
    );

    // Bit W of the sign-extended sum: both sign bits plus the carry into bit W.
    assign y_full = {sh1[HI-1] ^ ch1[HI-1] ^ hi_co, hi_sum, lo1};

`ifdef CSA_RESOLVE_SAT_EN
    localparam logic [W:0] SAT_HI = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0] SAT_LO = {2'b11, {(W-1){1'b0}}};

    always_comb begin
        clamp  = y_full[W] ^ y_full[W-1];
        y_next = y_full;
        if (clamp) begin
            y_next = y_full[W] ? SAT_LO : SAT_HI;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            ovf     <= 1'b0;
            sat_cnt <= 8'd0;
        end else begin
            if (out_valid && out_ready && ovf && (sat_cnt != 8'hFF)) begin
                sat_cnt <= sat_cnt + 8'd1;
            end
            if (en) begin
                ovf <= v1 & clamp;
            end
        end
    end
`else
    always_comb begin
        clamp  = 1'b0;
        y_next = y_full;
    end

    assign ovf     = clamp;
    assign sat_cnt = 8'd0;
`endif

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (en) begin
            out_valid <= v1;
            out_y     <= y_next;
        end
    end

endmodule

// File: tb/tb_csa_resolve.sv
// Directed bench for csa_resolve: single items, split carry, saturation, stall, reset flush.
module tb_csa_resolve;

    logic        clk;
    logic        r;
    logic [9:0]  s;
    logic [9:0]  c;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] out_y;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic [7:0]  sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    csa_resolve #(.W(10), .SPLIT(5)) dut (
        .clk       (clk),
        .r         (r),
        .s         (s),
        .c         (c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_y     (out_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .sat_cnt   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ysig();
        return int'($signed(out_y));
    endfunction

    task automatic send_one(input string tag, input logic [9:0] sv, input logic [9:0] cv,
                            input int ey, input int eo);
        @(negedge clk);
        s = sv; c = cv; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_y"}, ysig(), ey);
        chk({tag, "_ovf"}, int'(ovf), eo);
    endtask

    logic [9:0] st_s [4] = '{10'h001, 10'h002, 10'h010, 10'h3FF};
    logic [9:0] st_c [4] = '{10'h001, 10'h002, 10'h010, 10'h001};
    int         st_y [4] = '{2, 4, 32, 0};

    initial begin
        int tx, rx, stalls;

        r = 1'b1; s = '0; c = '0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_y", ysig(), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_satcnt", int'(sat_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        r = 1'b0;

        send_one("small", 10'h005, 10'h003, 8, 0);
        send_one("split", 10'h01F, 10'h001, 32, 0);
        send_one("carry2", 10'h0F0, 10'h010, 256, 0);
        send_one("zero", 10'h3E0, 10'h020, 0, 0);
        send_one("negneg", 10'h3FF, 10'h3FF, -2, 0);
`ifdef CSA_RESOLVE_SAT_EN
        send_one("posov", 10'h1FF, 10'h001, 511, 1);
        @(negedge clk);
        chk("posov_satcnt", int'(sat_cnt), 1);
        send_one("negov", 10'h200, 10'h3FF, -512, 1);
        @(negedge clk);
        chk("negov_satcnt", int'(sat_cnt), 2);
`else
        send_one("posov", 10'h1FF, 10'h001, 512, 0);
        @(negedge clk);
        chk("posov_satcnt", int'(sat_cnt), 0);
        send_one("negov", 10'h200, 10'h3FF, -513, 0);
        @(negedge clk);
        chk("negov_satcnt", int'(sat_cnt), 0);
`endif

        // Stream four items, stalling the output for three cycles.
        tx = 0; rx = 0; stalls = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            in_valid  = (tx < 4);
            s         = (tx < 4) ? st_s[tx] : 10'h000;
            c         = (tx < 4) ? st_c[tx] : 10'h000;
            out_ready = !(k >= 3 && k < 6);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_hold_y", ysig(), (rx < 4) ? st_y[rx] : -9999);
            end
            if (out_valid && out_ready) begin
                chk("stream_y", ysig(), (rx < 4) ? st_y[rx] : -9999);
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_tx", tx, 4);
        chk("stream_rx", rx, 4);
        chk("stream_stalls", stalls, 3);
        chk("stream_drained", int'(out_valid), 0);

        // Reset with two items in flight.
        @(negedge clk);
        s = 10'h007; c = 10'h001; in_valid = 1'b1;
        @(negedge clk);
        s = 10'h009; c = 10'h001;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        r = 1'b1;
        #1;
        chk("rst_now_valid", int'(out_valid), 0);
        chk("rst_now_y", ysig(), 0);
        @(negedge clk);
        r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale", int'(out_valid), 0);
        end
        send_one("post_rst", 10'h00C, 10'h004, 16, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/csa_resolve.md
CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
REQ-001 The block SHALL take parameter W, default 10, as the width of the carry-save sum/carry vectors.
REQ-002 The block SHALL take parameter SPLIT, default 5, as the number of low bits added in stage 1; the remaining W-SPLIT bits SHALL be added in stage 2.
REQ-003 The block SHALL have port clk, input, 1, as the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port r, input, 1, as the asynchronous, active-high reset.
REQ-005 The block SHALL have port s, input, W, as the carry-save sum vector (two's complement).
REQ-006 The block SHALL have port c, input, W, as the carry-save carry vector (two's complement, already weight-aligned).
REQ-007 The block SHALL have port in_valid, input, 1, meaning s/c are presented for capture.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts s/c this cycle.
REQ-009 The block SHALL have port out_y, output, W+1, as the resolved binary result.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_y is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream consumes out_y this cycle.
REQ-012 The block SHALL have port ovf, output, 1, as the saturation flag qualified by out_valid.
REQ-013 The block SHALL have port sat_cnt, output, 8, as the count of saturated results.

Function
REQ-014 Result SHALL be sign-extend(s) + sign-extend(c), computed in W+1 bits with no wrap.
REQ-015 Stage 1 SHALL register the low-SPLIT-bit sum, its carry-out and the untouched upper bits of s and c.
REQ-016 Stage 2 SHALL add the upper bits plus the registered carry and register out_y.
REQ-017 Pipeline enable SHALL be en = !out_valid | out_ready; both stages advance only when en=1.
REQ-018 in_ready SHALL equal en; a transfer occurs when in_valid & in_ready.
REQ-019 Latency SHALL be exactly 2 cycles from transfer to out_valid when unstalled; throughput 1 per cycle.
REQ-020 While stalled (out_valid & !out_ready), out_y, ovf and all stage registers SHALL hold.
REQ-021 Valid bits SHALL propagate with the data; a bubble (in_valid=0) SHALL advance as a bubble.
REQ-022 A carry out of bit SPLIT-1 SHALL be applied in stage 2 of the same item and never to a neighbouring item.

Reset
REQ-023 While r=1, stage valid bits, out_valid, out_y, ovf and sat_cnt SHALL be 0, asynchronously.
REQ-024 Items in flight when r asserts SHALL be discarded; the first output after reset SHALL come from an item transferred after r deasserts.

Configuration
REQ-025 With CSA_RESOLVE_SAT_EN defined, out_y SHALL be clamped to [-2^(W-1), 2^(W-1)-1] and ovf SHALL be 1 exactly when clamping occurred.
REQ-026 With CSA_RESOLVE_SAT_EN defined, sat_cnt SHALL increment once per output transfer with ovf=1 and saturate at 255.
REQ-027 Without CSA_RESOLVE_SAT_EN, out_y SHALL be the full W+1-bit sum, and ovf and sat_cnt SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-028 Package csa_pkg SHALL hold W, SPLIT, the SAT_MAX/SAT_MIN constants and the result typedef, shared with the carry-save block.
REQ-029 A single sub-module, csa_res_slice, SHALL implement an N-bit adder with carry-in and carry-out, instantiated once per stage.

Verification
REQ-030 The bench SHALL apply s=10'h005, c=10'h003, in_valid=1 and check out_y=8 and out_valid=1 two cycles later with ovf=0.
REQ-031 The bench SHALL apply s=10'h01F, c=10'h001 and check out_y=32, confirming the split carry.
REQ-032 The bench SHALL apply s=10'h1FF, c=10'h001; with SAT_EN it SHALL check out_y=511, ovf=1 and sat_cnt=1, and without SAT_EN it SHALL check out_y=512.
REQ-033 The bench SHALL apply s=10'h200, c=10'h3FF; with SAT_EN it SHALL check out_y=-512 and ovf=1, and without SAT_EN it SHALL check out_y=-513.
REQ-034 The bench SHALL stream 4 items, hold out_ready=0 for 3 cycles, and check that in_ready=0, out_y holds, and no item is lost or duplicated.
REQ-035 The bench SHALL pulse r with 2 items in flight and check that out_valid=0 immediately and no stale item emerges afterwards.
